// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and decode helpers for the MDU
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_RUN  = 2'b10,
        S_FIX  = 2'b11
    } mdu_state_e;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div(input logic [1:0] op);
        return (op == MDU_DIVU) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    // Divide: acc = {remainder, remaining dividend bits}, shifting left; the
    // quotient bit leaves bit 0 clear and is merged by the caller.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        acc_next = acc;
        q_bit    = 1'b0;
        if (div_mode) begin
            q_bit = ~diff[WIDTH];
            if (q_bit) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative MULT/DIV sequencer owning HI/LO with pipeline stall
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hilo_rd_i,
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] hilo_wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e state, state_next;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd;
    logic [2*WIDTH-1:0] acc, step_acc, prod_fix;
    logic               q_bit;
    logic [CW-1:0]      cnt;
    logic               neg_res, neg_rem;
    logic [WIDTH-1:0]   abs1, abs2, quo_fix, rem_fix;
    logic [WIDTH-1:0]   hi, lo;
    logic               busy, done;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .div_mode (is_div(op_q)),
        .acc_next (step_acc),
        .q_bit    (q_bit)
    );

    always_comb begin
        abs1     = (is_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
        abs2     = (is_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_i) state_next = S_PREP;
            S_PREP: state_next = S_RUN;
            S_RUN:  if (cnt == '0) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd    <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    // A start in the same cycle as an MT write takes priority.
                    if (start_i) begin
                        op_q <= op_i;
                        a_q  <= src1_i;
                        b_q  <= src2_i;
                    end else begin
                        if (hilo_we_i[1]) hi <= hilo_wdata_i;
                        if (hilo_we_i[0]) lo <= hilo_wdata_i;
                    end
                end
                S_PREP: begin
                    acc     <= {{WIDTH{1'b0}}, abs1};
                    opnd    <= abs2;
                    neg_res <= is_signed(op_q) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem <= is_signed(op_q) & a_q[WIDTH-1];
                    cnt     <= CW'(WIDTH - 1);
                end
                S_RUN: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (!is_div(op_q)) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_q == '0) begin
                        hi <= a_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o    = hi;
    assign lo_o    = lo;
    assign busy_o  = busy;
    assign done_o  = done;
    assign stall_o = busy & (start_i | hilo_rd_i | (|hilo_we_i));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for the iterative multiply/divide sequencer
module tb_mdu_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  src1 = '0;
    logic [W-1:0]  src2 = '0;
    logic          hilo_rd = 1'b0;
    logic [1:0]    hilo_we = 2'b00;
    logic [W-1:0]  hilo_wdata = '0;
    logic [W-1:0]  hi, lo;
    logic          busy, stall, done;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .op_i         (op),
        .src1_i       (src1),
        .src2_i       (src2),
        .hilo_rd_i    (hilo_rd),
        .hilo_we_i    (hilo_we),
        .hilo_wdata_i (hilo_wdata),
        .hi_o         (hi),
        .lo_o         (lo),
        .busy_o       (busy),
        .stall_o      (stall),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: return 64'(sa * sb);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = a / b;
                r = a % b;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        int n;
        int busy_bad;
        logic [63:0] e;
        exp_q.push_back(model(o, a, b));
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_bad = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != W + 3) begin
            failures++;
            $display("FAIL %s latency: done at cycle %0d, expected %0d", name, n, W + 3);
        end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: %0d bad busy cycles, busy at done=%b expected 0", name, busy_bad, busy);
        end
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) begin
            failures++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b expected all 0", hi, lo, busy, done, stall);
        end
    endtask

    task automatic test_known_results();
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            failures++;
            $display("FAIL multu_max const: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        run_op(2'b01, 32'hFFFFFFF9, 32'd3, "mult_neg");
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            failures++;
            $display("FAIL mult_neg const: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, "div_neg");
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            failures++;
            $display("FAIL div_neg const: got %h_%h expected ffffffff_fffffffd", hi, lo);
        end
        run_op(2'b10, 32'd100, 32'd0, "divu_zero");
        checks++;
        if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin
            failures++;
            $display("FAIL divu_zero const: got %h_%h expected 00000064_ffffffff", hi, lo);
        end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin
            failures++;
            $display("FAIL div_ovf const: got %h_%h expected 00000000_80000000", hi, lo);
        end
        run_op(2'b11, 32'hFFFFFC18, 32'd0, "div_zero_neg");
    endtask

    task automatic test_hilo_stall();
        int n;
        logic [63:0] e;
        logic [31:0] saved_hi;
        exp_q.push_back(model(2'b01, 32'd123456, 32'hFFFFFF00));
        op = 2'b01; src1 = 32'd123456; src2 = 32'hFFFFFF00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        hilo_rd = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_rd_busy: stall=%b expected 1", stall);
        end
        hilo_rd = 1'b0;
        hilo_we = 2'b01;
        hilo_wdata = 32'h1234;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_we_busy: stall=%b expected 1", stall);
        end
        @(negedge clk);
        hilo_we = 2'b00;
        n++;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        hilo_rd = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_rd_done: stall=%b expected 0", stall);
        end
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) begin
            failures++;
            $display("FAIL busy_mtlo_ignored: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
        @(negedge clk);
        hilo_rd = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b expected 0", done);
        end
        saved_hi = hi;
        hilo_we = 2'b01;
        hilo_wdata = 32'h1234;
        @(negedge clk);
        hilo_we = 2'b00;
        checks++;
        if (lo !== 32'h1234 || hi !== saved_hi) begin
            failures++;
            $display("FAIL mtlo_idle: hi=%h lo=%h expected hi=%h lo=00001234", hi, lo, saved_hi);
        end
        hilo_we = 2'b10;
        hilo_wdata = 32'hABCD;
        @(negedge clk);
        checks++;
        if (hi !== 32'hABCD || lo !== 32'h1234) begin
            failures++;
            $display("FAIL mthi_idle: hi=%h lo=%h expected hi=0000abcd lo=00001234", hi, lo);
        end
        hilo_we = 2'b11;
        hilo_wdata = 32'hDEAD;
        start = 1'b1;
        op = 2'b10; src1 = 32'd77; src2 = 32'd5;
        exp_q.push_back(model(2'b10, 32'd77, 32'd5));
        @(negedge clk);
        start = 1'b0;
        hilo_we = 2'b00;
        checks++;
        if (hi !== 32'hABCD || lo !== 32'h1234 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_beats_mt: hi=%h lo=%h busy=%b expected hi=0000abcd lo=00001234 busy=1", hi, lo, busy);
        end
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e || n != W + 3) begin
            failures++;
            $display("FAIL divu_after_mt: got hi=%h lo=%h cycle %0d expected hi=%h lo=%h cycle %0d", hi, lo, n, e[63:32], e[31:0], W + 3);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] e;
        exp_q.push_back(model(2'b00, 32'd12345, 32'd6789));
        exp_q.push_back(model(2'b11, 32'hFFFFFC18, 32'd7));
        op = 2'b00; src1 = 32'd12345; src2 = 32'd6789; start = 1'b1;
        @(negedge clk);
        n = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall: stall=%b expected 1", stall);
        end
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if (n != W + 3 || {hi, lo} !== e) begin
            failures++;
            $display("FAIL b2b_first: cycle %0d hi=%h lo=%h expected cycle %0d hi=%h lo=%h", n, hi, lo, W + 3, e[63:32], e[31:0]);
        end
        op = 2'b11; src1 = 32'hFFFFFC18; src2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++;
        if (n != 2 * (W + 3) || {hi, lo} !== e) begin
            failures++;
            $display("FAIL b2b_second: cycle %0d hi=%h lo=%h expected cycle %0d hi=%h lo=%h", n, hi, lo, 2 * (W + 3), e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw_done;
        op = 2'b10; src1 = 32'd1000000; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (hi !== 0 || lo !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_abort: activity after reset=1 expected 0");
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 5) a = 32'hFFFFFFFF;
            run_op(o, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_known_results();
        test_hilo_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
